microtile_scan_sequencer: RTL and testbench

Sequences exhaustive or ranged stimulus sweeps into combinational 8-in/8-out microtiles on a board or test harness. Drives one shared 8-bit stimulus bus to all tiles and selects one tile's 8-bit output. Each output is folded into a 16-bit signature, giving a self-check of any microtile with no external capture. Sits between the harness control logic and the tile array, and owns the tiles' ui_in bus.

---
 rtl/microtile_seq_pkg.sv | 21 ++
 rtl/microtile_sig_accum.sv | 44 ++++
 rtl/microtile_scan_sequencer.sv | 127 ++++++++++++
 tb/tb_microtile_scan_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microtile_seq_pkg.sv
// Shared types, widths and the signature step function for the microtile scan sequencer.
package microtile_seq_pkg;

  localparam int unsigned SIG_W     = 16;
  localparam int unsigned VEC_CNT_W = 9;
  localparam int unsigned SETTLE_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } scan_state_e;

  // Rotate left by one, then fold in the zero-extended tile output.
  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                input logic [7:0]       sample);
    return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ SIG_W'(sample);
  endfunction

endpackage

// File: rtl/microtile_sig_accum.sv
// Signature register and sampled-vector counter; cleared at sweep start, stepped per sample.
module microtile_sig_accum
  import microtile_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 step,
  input  logic [7:0]           sample,
  output logic [SIG_W-1:0]     signature,
  output logic [VEC_CNT_W-1:0] vec_count
);

  logic [SIG_W-1:0]     sig_q, sig_d;
  logic [VEC_CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over step; they never coincide in practice since start is IDLE-only.
  always_comb begin
    sig_d = sig_q;
    cnt_d = cnt_q;
    if (clear) begin
      sig_d = '0;
      cnt_d = '0;
    end else if (step) begin
      sig_d = sig_step(sig_q, sample);
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Accumulator state; holds between sweeps so results stay readable in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
      cnt_q <= '0;
    end else begin
      sig_q <= sig_d;
      cnt_q <= cnt_d;
    end
  end

  assign signature = sig_q;
  assign vec_count = cnt_q;

endmodule

// File: rtl/microtile_scan_sequencer.sv
// Sweeps a stimulus range across a shared tile input bus and folds one tile's outputs
// into a running signature.
module microtile_scan_sequencer
  import microtile_seq_pkg::*;
#(
  parameter int unsigned NUM_TILES     = 4,
  parameter int unsigned SEL_W         = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SEL_W-1:0]       tile_sel,
  input  logic [7:0]             first_vec,
  input  logic [7:0]             last_vec,
  output logic [7:0]             tile_ui_in,
  input  logic [NUM_TILES*8-1:0] tile_uo_out,
  output logic                   busy,
  output logic                   done,
  output logic [SIG_W-1:0]       signature,
  output logic [VEC_CNT_W-1:0]   vec_count
);

  localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES - 1);

  scan_state_e         state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [7:0]          ui_q, ui_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [7:0]          last_q, last_d;
  logic                acc_clear, acc_step;
  logic [7:0]          sample;

  // Next-state logic: latch the sweep at start, settle, sample, advance or finish.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    ui_d      = ui_q;
    sel_d     = sel_q;
    last_d    = last_q;
    acc_clear = 1'b0;
    acc_step  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d   = StDrive;
          sel_d     = tile_sel;
          last_d    = last_vec;
          ui_d      = first_vec;
          settle_d  = SettleLoad;
          acc_clear = 1'b1;
        end
      end
      StDrive: begin
        if (abort) begin
          state_d = StIdle;
        end else if (settle_q == '0) begin
          state_d = StSample;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      StSample: begin
        // The sample is taken even when abort lands on this edge.
        acc_step = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (ui_q == last_q) begin
          state_d = StDone;
        end else begin
          ui_d     = ui_q + 8'd1;
          settle_d = SettleLoad;
          state_d  = StDrive;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
      ui_q     <= '0;
      sel_q    <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ui_q     <= ui_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
    end
  end

  // Output select; an out-of-range tile index reads as 0x00.
  always_comb begin
    sample = 8'h00;
    for (int k = 0; k < NUM_TILES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sample = tile_uo_out[8*k +: 8];
      end
    end
  end

  microtile_sig_accum u_sig_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (acc_clear),
    .step      (acc_step),
    .sample    (sample),
    .signature (signature),
    .vec_count (vec_count)
  );

  assign tile_ui_in = ui_q;
  assign busy       = (state_q == StDrive) || (state_q == StSample);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_microtile_scan_sequencer.sv
// Self-checking bench: three tiles (identity, random LUT, inverter); tile_sel=3 is out of range.
module tb_microtile_scan_sequencer;

  localparam int unsigned NumTiles = 3;
  localparam int unsigned SelW     = 2;
  localparam int unsigned Settle   = 2;
  localparam int          Cost     = Settle + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic [SelW-1:0]       tile_sel = '0;
  logic [7:0]            first_vec = '0;
  logic [7:0]            last_vec = '0;
  logic [7:0]            tile_ui_in;
  logic [NumTiles*8-1:0] tile_uo_out;
  logic                  busy;
  logic                  done;
  logic [15:0]           signature;
  logic [8:0]            vec_count;
  logic [7:0]            lut [256];
  int                    tests_run = 0;
  int                    failures = 0;

  always #5 clk = ~clk;

  assign tile_uo_out = {~tile_ui_in, lut[tile_ui_in], tile_ui_in};

  microtile_scan_sequencer #(
    .NUM_TILES     (NumTiles),
    .SEL_W         (SelW),
    .SETTLE_CYCLES (Settle)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .tile_sel    (tile_sel),
    .first_vec   (first_vec),
    .last_vec    (last_vec),
    .tile_ui_in  (tile_ui_in),
    .tile_uo_out (tile_uo_out),
    .busy        (busy),
    .done        (done),
    .signature   (signature),
    .vec_count   (vec_count)
  );

  // Reference: what tile t produces for stimulus v.
  function automatic logic [7:0] model_tile(input int t, input int v);
    case (t)
      0:       return 8'(v);
      1:       return lut[v];
      2:       return 8'(255 - v);
      default: return 8'h00;
    endcase
  endfunction

  // Reference: walk the inclusive, wrapping range and fold each output in.
  task automatic model_sweep(input int f, input int l, input int t,
                             output logic [15:0] sig, output int n);
    int v;
    int s;
    bit fin;
    s   = 0;
    n   = 0;
    v   = f;
    fin = 0;
    while (!fin) begin
      s = (((s * 2) % 65536) + (s / 32768)) ^ int'(model_tile(t, v));
      n++;
      if (v == l) fin = 1;
      else v = (v + 1) % 256;
    end
    sig = 16'(s);
  endtask

  // Called one ns after an edge; start is sampled on the following edge (edge 0).
  task automatic do_start(input int sel, input int f, input int l);
    tile_sel  = SelW'(sel);
    first_vec = 8'(f);
    last_vec  = 8'(l);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int edges, output bit seen);
    edges = 0;
    seen  = 0;
    for (int i = 1; i <= max && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        edges = i;
        seen  = 1;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (tile_ui_in !== 8'h00) begin
      failures++; $display("FAIL reset_ui: got %h want 00", tile_ui_in);
    end
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
    end
    tests_run++;
    if (signature !== 16'h0000 || vec_count !== 9'd0) begin
      failures++; $display("FAIL reset_acc: got sig=%h cnt=%0d want 0000 0", signature, vec_count);
    end
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_identity();
    int bad;
    bad = 0;
    do_start(0, 8'h01, 8'h03);
    tests_run++;
    if (tile_ui_in !== 8'h01 || busy !== 1'b1) begin
      failures++; $display("FAIL ident_first: got ui=%h busy=%b want 01 1", tile_ui_in, busy);
    end
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (tile_ui_in !== 8'(1 + e / 3) || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      failures++; $display("FAIL ident_seq: got %0d bad cycles want 0", bad);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL ident_done: got done=%b busy=%b want 1 0", done, busy);
    end
    tests_run++;
    if (signature !== 16'h0003 || vec_count !== 9'd3) begin
      failures++; $display("FAIL ident_acc: got sig=%h cnt=%0d want 0003 3", signature, vec_count);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL ident_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_single();
    int busy_cycles;
    bit seen;
    busy_cycles = 0;
    seen = 0;
    do_start(2, 8'h00, 8'h00);
    for (int e = 1; e <= 20 && !seen; e++) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1;
    end
    tests_run++;
    if (!seen || busy_cycles != 3) begin
      failures++; $display("FAIL single_busy: got %0d busy cycles want 3", busy_cycles);
    end
    tests_run++;
    if (signature !== 16'h00FF || vec_count !== 9'd1) begin
      failures++; $display("FAIL single_acc: got sig=%h cnt=%0d want 00ff 1", signature, vec_count);
    end
    @(posedge clk);
    #1;
  endtask

  // Out-of-range tile_sel doubles as the constant-zero tile.
  task automatic test_full_wrap();
    int edges;
    bit seen;
    bit wrapped;
    logic [7:0] prev;
    edges = 0;
    seen = 0;
    wrapped = 0;
    prev = 8'h00;
    do_start(3, 8'h01, 8'h00);
    for (int e = 1; e <= 256 * Cost + 10 && !seen; e++) begin
      prev = tile_ui_in;
      @(posedge clk);
      #1;
      if (prev === 8'hFF && tile_ui_in === 8'h00) wrapped = 1;
      if (done === 1'b1) begin
        seen  = 1;
        edges = e;
      end
    end
    tests_run++;
    if (!seen || edges != 256 * Cost) begin
      failures++; $display("FAIL wrap_time: got edge %0d want %0d", edges, 256 * Cost);
    end
    tests_run++;
    if (vec_count !== 9'd256 || signature !== 16'h0000) begin
      failures++; $display("FAIL wrap_acc: got sig=%h cnt=%0d want 0000 256", signature, vec_count);
    end
    tests_run++;
    if (!wrapped) begin
      failures++; $display("FAIL wrap_ff00: got no FF->00 step want one");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    logic [15:0] exp_sig;
    int n;
    int bad;
    bad = 0;
    model_sweep(8'h10, 8'h12, 0, exp_sig, n);
    do_start(0, 8'h10, 8'h1F);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1) bad++;
      if (e == 4) begin
        // Restart attempt mid-sweep with different parameters must be ignored.
        tile_sel  = 2'd2;
        first_vec = 8'h80;
        last_vec  = 8'h85;
        start     = 1'b1;
      end
      if (e == 5) start = 1'b0;
      if (e == 8) abort = 1'b1;
    end
    @(posedge clk);
    #1;
    abort = 1'b0;
    tests_run++;
    if (bad != 0) begin
      failures++; $display("FAIL abort_busy_run: got %0d idle cycles want 0", bad);
    end
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL abort_flags: got busy=%b done=%b want 0 0", busy, done);
    end
    tests_run++;
    if (signature !== exp_sig || vec_count !== 9'(n)) begin
      failures++;
      $display("FAIL abort_acc: got sig=%h cnt=%0d want %h %0d", signature, vec_count, exp_sig, n);
    end
    tests_run++;
    if (tile_ui_in !== 8'h12) begin
      failures++; $display("FAIL abort_ui: got %h want 12", tile_ui_in);
    end
    bad = 0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      failures++; $display("FAIL abort_no_done: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_sig;
    int n;
    int edges;
    bit seen;
    model_sweep(8'h40, 8'h41, 1, exp_sig, n);
    do_start(1, 8'h40, 8'h41);
    wait_done(20, edges, seen);
    tests_run++;
    if (!seen || edges != 2 * Cost) begin
      failures++; $display("FAIL b2b_time: got edge %0d want %0d", edges, 2 * Cost);
    end
    // Start during the DONE cycle is dropped.
    tile_sel  = 2'd2;
    first_vec = 8'h50;
    last_vec  = 8'h50;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (busy !== 1'b0 || tile_ui_in !== 8'h41) begin
      failures++; $display("FAIL b2b_ignored: got busy=%b ui=%h want 0 41", busy, tile_ui_in);
    end
    tests_run++;
    if (signature !== exp_sig || vec_count !== 9'(n)) begin
      failures++;
      $display("FAIL b2b_hold: got sig=%h cnt=%0d want %h %0d", signature, vec_count, exp_sig, n);
    end
    do_start(2, 8'h50, 8'h50);
    wait_done(20, edges, seen);
    tests_run++;
    if (!seen || edges != Cost || signature !== 16'h00AF) begin
      failures++; $display("FAIL b2b_restart: got edge %0d sig=%h want %0d 00af", edges, signature,
                           Cost);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int bad;
    do_start(1, 8'h00, 8'hFF);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (tile_ui_in !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rstmid_ctl: got ui=%h busy=%b done=%b want 00 0 0", tile_ui_in,
                           busy, done);
    end
    tests_run++;
    if (signature !== 16'h0000 || vec_count !== 9'd0) begin
      failures++; $display("FAIL rstmid_acc: got sig=%h cnt=%0d want 0000 0", signature, vec_count);
    end
    #2 rst_n = 1'b1;
    bad = 0;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      failures++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad);
    end
    // start and abort together in IDLE: nothing happens.
    tile_sel  = 2'd0;
    first_vec = 8'h33;
    last_vec  = 8'h33;
    start     = 1'b1;
    abort     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || tile_ui_in !== 8'h00 || done !== 1'b0) begin
      failures++; $display("FAIL start_abort: got busy=%b ui=%h done=%b want 0 00 0", busy,
                           tile_ui_in, done);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_sig;
    int n;
    int f;
    int l;
    int len;
    int sel;
    int edges;
    bit seen;
    for (int r = 0; r < 8; r++) begin
      f   = int'($urandom_range(0, 255));
      len = int'($urandom_range(1, 40));
      l   = (f + len - 1) % 256;
      sel = int'($urandom_range(0, 3));
      model_sweep(f, l, sel, exp_sig, n);
      do_start(sel, f, l);
      wait_done(256 * Cost + 10, edges, seen);
      tests_run++;
      if (!seen || edges != n * Cost) begin
        failures++; $display("FAIL rand%0d_time: got edge %0d want %0d", r, edges, n * Cost);
      end
      tests_run++;
      if (signature !== exp_sig || vec_count !== 9'(n)) begin
        failures++; $display("FAIL rand%0d_acc: got sig=%h cnt=%0d want %h %0d", r, signature,
                             vec_count, exp_sig, n);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
    test_reset();
    test_identity();
    test_single();
    test_full_wrap();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
